// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch with PC, IF/ID pipeline register,
// hazard stall, branch redirect/flush and a one-entry skid buffer.
module fetch_stage #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              if_id_valid,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc4,
  output logic [5:0]        op_code,
  output logic [5:0]        funct_field,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm16
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              if_id_valid_q;
  logic [31:0]       if_id_instr_q;
  logic [ADDR_W-1:0] if_id_pc4_q;
  logic [31:0]       skid_instr_q;
  logic [ADDR_W-1:0] skid_pc4_q;

  logic [ADDR_W-1:0] pc4_d;
  logic [ADDR_W-1:0] redirect_pc_d;

  // The two low target bits are dropped when the redirect address is aligned.
  logic [1:0] unused_target_lsbs;
  assign unused_target_lsbs = branch_target[1:0];

  // Sequential next PC wraps naturally modulo 2^ADDR_W.
  assign pc4_d         = pc_q + ADDR_W'(4);
  assign redirect_pc_d = {branch_target[ADDR_W-1:2], 2'b00};

  assign imem_req  = (state_q == FETCH) && !reset;
  assign imem_addr = {pc_q[ADDR_W-1:2], 2'b00};

  assign if_id_valid = if_id_valid_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc4   = if_id_pc4_q;

  // Decode fields are plain slices; a bubble holds 0, which decodes as NOP.
  assign op_code     = if_id_instr_q[31:26];
  assign funct_field = if_id_instr_q[5:0];
  assign rs          = if_id_instr_q[25:21];
  assign rt          = if_id_instr_q[20:16];
  assign rd          = if_id_instr_q[15:11];
  assign imm16       = if_id_instr_q[15:0];

  // Fetch FSM: reset, then branch redirect, then stall/valid handling per state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= '0;
      if_id_pc4_q   <= '0;
      skid_instr_q  <= '0;
      skid_pc4_q    <= '0;
    end else if (branch_taken) begin
      state_q       <= FETCH;
      pc_q          <= redirect_pc_d;
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= '0;
      skid_instr_q  <= '0;
      skid_pc4_q    <= '0;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_valid && !stall) begin
            if_id_valid_q <= 1'b1;
            if_id_instr_q <= imem_rdata;
            if_id_pc4_q   <= pc4_d;
            pc_q          <= pc4_d;
          end else if (imem_valid && stall) begin
            skid_instr_q <= imem_rdata;
            skid_pc4_q   <= pc4_d;
            state_q      <= HOLD;
          end else if (!stall) begin
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= '0;
          end
        end
        HOLD: begin
          if (!stall) begin
            if_id_valid_q <= 1'b1;
            if_id_instr_q <= skid_instr_q;
            if_id_pc4_q   <= skid_pc4_q;
            pc_q          <= pc4_d;
            skid_instr_q  <= '0;
            skid_pc4_q    <= '0;
            state_q       <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors for fetch_stage, plus a wrapping-PC instance.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        imem_valid;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [5:0]  op_code;
  logic [5:0]  funct_field;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;

  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_rdata;
  logic        w_if_id_valid;
  logic [31:0] w_if_id_instr;
  logic [31:0] w_if_id_pc4;
  logic [5:0]  w_op_code;
  logic [5:0]  w_funct_field;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm16;

  int testsRun;
  int testsFailed;

  // Address-tagged instruction word so every fetch slot is distinguishable.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[7:2], a[11:8] ^ 4'hA, 16'h5EED, ~a[7:2]};
  endfunction

  assign imem_rdata   = imem_valid ? memWord(imem_addr)   : 32'hDEAD_BEEF;
  assign w_imem_rdata = imem_valid ? memWord(w_imem_addr) : 32'hDEAD_BEEF;

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .op_code(op_code), .funct_field(funct_field),
    .rs(rs), .rt(rt), .rd(rd), .imm16(imm16)
  );

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) dutWrap (
    .clk(clk), .reset(reset),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_rdata(w_imem_rdata), .imem_valid(imem_valid),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .if_id_valid(w_if_id_valid), .if_id_instr(w_if_id_instr), .if_id_pc4(w_if_id_pc4),
    .op_code(w_op_code), .funct_field(w_funct_field),
    .rs(w_rs), .rt(w_rt), .rd(w_rd), .imm16(w_imm16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        st;
    logic        br;
    logic [31:0] tgt;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expInstrAddr;
    logic [31:0] expPc4;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge.
  task automatic applyStimulus(input logic iv, input logic st, input logic br, input logic [31:0] tgt);
    @(negedge clk);
    imem_valid    = iv;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset        = 1'b1;
    imem_valid   = 1'b0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    #1 checkOutput("reset_req_low", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic checkIfId(input string tag, input logic expValid, input logic [31:0] expInstr,
                           input logic [31:0] expPc4, input logic chkPc4);
    checkOutput({tag, "_valid"}, {31'b0, if_id_valid}, {31'b0, expValid});
    checkOutput({tag, "_instr"}, if_id_instr, expInstr);
    if (chkPc4) checkOutput({tag, "_pc4"}, if_id_pc4, expPc4);
    checkOutput({tag, "_op"}, {26'b0, op_code}, {26'b0, expInstr[31:26]});
    checkOutput({tag, "_funct"}, {26'b0, funct_field}, {26'b0, expInstr[5:0]});
    checkOutput({tag, "_rs"}, {27'b0, rs}, {27'b0, expInstr[25:21]});
    checkOutput({tag, "_rt"}, {27'b0, rt}, {27'b0, expInstr[20:16]});
    checkOutput({tag, "_rd"}, {27'b0, rd}, {27'b0, expInstr[15:11]});
    checkOutput({tag, "_imm"}, {16'b0, imm16}, {16'b0, expInstr[15:0]});
  endtask

  initial begin
    logic [31:0] expInstr;
    testsRun    = 0;
    testsFailed = 0;
    reset = 1'b1; imem_valid = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;

    // iv st br tgt | req addr | valid instrAddr pc4
    vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h00, 1'b1, 32'h00, 32'h04});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h04, 1'b1, 32'h04, 32'h08});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h08, 1'b1, 32'h04, 32'h08});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h08, 1'b1, 32'h04, 32'h08});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h08, 1'b1, 32'h04, 32'h08});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h08, 1'b1, 32'h04, 32'h08});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h08, 1'b1, 32'h08, 32'h0C});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0C, 1'b1, 32'h0C, 32'h10});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10, 1'b0, 32'h00, 32'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10, 1'b0, 32'h00, 32'h00});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10, 1'b1, 32'h10, 32'h14});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h14, 1'b1, 32'h10, 32'h14});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h42,  1'b0, 32'h14, 1'b0, 32'h00, 32'h00});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h40, 1'b1, 32'h40, 32'h44});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h103, 1'b1, 32'h44, 1'b0, 32'h00, 32'h00});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 32'h100, 32'h104});

    // Reset state.
    doReset();
    #1;
    checkOutput("rst_req", {31'b0, imem_req}, 32'd1);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_pc4", if_id_pc4, 32'h0);
    checkIfId("rst", 1'b0, 32'h0, 32'h0, 1'b0);

    // Memory idle for three cycles after reset: PC holds, NOPs presented.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      #1 checkOutput($sformatf("idle%0d_addr", i), imem_addr, 32'h0);
      @(posedge clk);
      #1 checkIfId($sformatf("idle%0d", i), 1'b0, 32'h0, 32'h0, 1'b0);
    end

    // Main vector table.
    doReset();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].iv, vecs[i].st, vecs[i].br, vecs[i].tgt);
      #1;
      checkOutput($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].expReq});
      checkOutput($sformatf("v%0d_addr", i), imem_addr, vecs[i].expAddr);
      @(posedge clk);
      #1;
      expInstr = vecs[i].expValid ? memWord(vecs[i].expInstrAddr) : 32'h0;
      checkIfId($sformatf("v%0d", i), vecs[i].expValid, expInstr, vecs[i].expPc4, vecs[i].expValid);
    end

    // Reset while in HOLD with a full skid: skid and IF/ID are discarded.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    #1 checkOutput("hold_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    #1;
    checkOutput("hrst_req", {31'b0, imem_req}, 32'd1);
    checkOutput("hrst_addr", imem_addr, 32'h0);
    checkIfId("hrst", 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1 checkIfId("hrst_fetch", 1'b1, memWord(32'h0), 32'h4, 1'b1);

    // PC wrap-around on the instance reset to 0xFFFF_FFF8.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    #1 checkOutput("wrap0_addr", w_imem_addr, 32'hFFFF_FFF8);
    @(posedge clk);
    #1;
    checkOutput("wrap0_pc4", w_if_id_pc4, 32'hFFFF_FFFC);
    checkOutput("wrap0_instr", w_if_id_instr, memWord(32'hFFFF_FFF8));
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    #1 checkOutput("wrap1_addr", w_imem_addr, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    checkOutput("wrap1_pc4", w_if_id_pc4, 32'h0);
    checkOutput("wrap1_instr", w_if_id_instr, memWord(32'hFFFF_FFFC));
    checkOutput("wrap1_valid", {31'b0, w_if_id_valid}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    #1 checkOutput("wrap2_addr", w_imem_addr, 32'h0);
    @(posedge clk);
    #1 checkOutput("wrap2_pc4", w_if_id_pc4, 32'h4);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
MIPS instruction-fetch stage and IF/ID pipeline register, directly upstream of the main/ALU control decode.
- Holds the PC and issues word reads to instruction memory.
- Captures returned instructions into the IF/ID register and presents op_code/funct_field plus register/immediate fields to decode and control.
- Supports hazard stall, branch redirect/flush, and a one-entry skid buffer so no fetched word is lost while stalled.

Parameters:
ADDR_W, 32, PC / memory address width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_W  word-aligned fetch address (= pc)
imem_rdata  in  32  instruction word, meaningful when imem_valid=1
imem_valid  in  1  memory returns data for the current imem_addr this cycle
stall  in  1  hazard unit: hold IF/ID and PC
branch_taken  in  1  redirect request, single-cycle pulse
branch_target  in  ADDR_W  redirect address
if_id_valid  out  1  IF/ID holds a real instruction
if_id_instr  out  32  IF/ID instruction word
if_id_pc4  out  ADDR_W  address of the IF/ID instruction + 4
op_code  out  6  if_id_instr[31:26]
funct_field  out  6  if_id_instr[5:0]
rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11]
imm16  out  16  instr[15:0]

Behaviour:
- Reset (synchronous, highest priority):
  - pc=RESET_PC, state=FETCH.
  - if_id_valid=0, if_id_instr=0, if_id_pc4=0, skid buffer empty.
  - imem_req=0 during the reset cycle.
- Decoded fields are pure slices of if_id_instr.
  - When if_id_valid=0, if_id_instr is 0 (sll $0,$0,0 = NOP), so control sees op_code=0 and funct=0.
- imem_req = (state==FETCH) && !reset. imem_addr = {pc[ADDR_W-1:2],2'b00}.
- Memory contract: imem_valid refers only to the address presented in the same cycle. The address may change on any cycle; there are no outstanding transactions.
- States: FETCH, HOLD.
- FETCH:
  - imem_valid && !stall: IF/ID <= {1, imem_rdata, pc+4}; pc <= pc+4; stay FETCH. Throughput is 1 instruction/cycle, latency 1 cycle from imem_valid to if_id_valid.
  - imem_valid && stall: IF/ID unchanged; skid <= {imem_rdata, pc+4}; pc unchanged; go HOLD.
  - !imem_valid && !stall: insert bubble (if_id_valid<=0, if_id_instr<=0); pc unchanged.
  - !imem_valid && stall: everything holds.
- HOLD:
  - imem_req=0.
  - stall=1: hold.
  - stall=0: IF/ID <= {1, skid}; pc <= pc+4; skid emptied; go FETCH. The next fetch is issued the following cycle.
- branch_taken (priority over stall and imem_valid, below reset):
  - pc <= {branch_target[ADDR_W-1:2],2'b00}; low target bits ignored.
  - IF/ID flushed to bubble (valid=0, instr=0); skid discarded; state <= FETCH.
  - Any imem_rdata in that cycle is dropped.
  - First redirected fetch is issued the next cycle.
- PC arithmetic is modulo 2^ADDR_W: pc=32'hFFFF_FFFC +4 wraps to 0, and if_id_pc4 wraps likewise.
- Reset asserted in HOLD or mid-stall discards the skid and the IF/ID contents.

Test Plan:
- Reset then memory always valid returning pc-tagged words → fetches at 0x0,0x4,0x8 on consecutive cycles; if_id_valid rises 1 cycle after first imem_valid; if_id_pc4 = 0x4,0x8,0xC; op_code/funct match slices of the word.
- imem_valid held low 3 cycles after reset → imem_addr stays 0x0, if_id_valid=0, op_code=0, funct_field=0 throughout.
- stall high 4 cycles while word W at 0x8 returns → enters HOLD, imem_req=0, IF/ID unchanged. Stall drop → IF/ID=W, pc4=0xC, next fetch at 0xC; no word lost or duplicated.
- branch_taken with target 0x0000_0042 while stall=1 and skid full → IF/ID flushed (valid=0), skid dropped, next imem_addr=0x0000_0040.
- RESET_PC=0xFFFF_FFF8, always valid → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0; if_id_pc4 = 0xFFFF_FFFC, 0x0.
- reset asserted for 1 cycle during HOLD → next cycle pc=RESET_PC, if_id_valid=0, state FETCH, imem_req=1.
